// File: rtl/mem_align_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_align_pkg
// Purpose  : Shared state encoding, size codes and lane helpers for the
//            byte-lane-aware memory alignment bridge.
// Revision : 1.0 - initial release
// ============================================================================
package mem_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Two-beat byte-enable window; callers keep the low 2*NB bits.
  function automatic logic [15:0] be_gen(input logic [2:0] off, input logic [1:0] size);
    logic [15:0] m;
    m = (16'd1 << (4'd1 << size)) - 16'd1;
    return m << off;
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] w, input logic [1:0] size,
                                         input logic uns);
    case (size)
      SZ_B:    return uns ? {56'd0, w[7:0]}  : {{56{w[7]}},  w[7:0]};
      SZ_H:    return uns ? {48'd0, w[15:0]} : {{48{w[15]}}, w[15:0]};
      SZ_W:    return uns ? {32'd0, w[31:0]} : {{32{w[31]}}, w[31:0]};
      default: return w;
    endcase
  endfunction

endpackage : mem_align_pkg
`default_nettype wire

// File: rtl/mem_align_shifter.sv
`default_nettype none
// ============================================================================
// Module   : mem_align_shifter
// Purpose  : Combinational lane datapath: write shift/byte-enable split and
//            read merge/shift/extend across two controller beats.
// Revision : 1.0 - initial release
// ============================================================================
module mem_align_shifter
  import mem_align_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic [OFF_W-1:0]  i_off,
  input  logic [1:0]        i_size,
  input  logic              i_uns,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_beat0,
  input  logic [DATA_W-1:0] i_beat1,
  output logic [DATA_W-1:0] o_wdata0,
  output logic [DATA_W-1:0] o_wdata1,
  output logic [NB-1:0]     o_be0,
  output logic [NB-1:0]     o_be1,
  output logic [DATA_W-1:0] o_rdata
);

  logic [63:0]         w_mask;
  logic [DATA_W-1:0]   w_masked;
  logic [2*DATA_W-1:0] w_wide;
  logic [15:0]         w_be16;
  logic [2*NB-1:0]     w_be2;
  logic [2*DATA_W-1:0] w_merge;
  logic [63:0]         w_ext;

  always_comb begin
    case (i_size)
      SZ_B:    w_mask = 64'h0000_0000_0000_00FF;
      SZ_H:    w_mask = 64'h0000_0000_0000_FFFF;
      SZ_W:    w_mask = 64'h0000_0000_FFFF_FFFF;
      default: w_mask = '1;
    endcase
    w_masked = i_wdata & w_mask[DATA_W-1:0];
    w_wide   = {{DATA_W{1'b0}}, w_masked} << {i_off, 3'b000};
    w_be16   = be_gen(3'(i_off), i_size);
    w_be2    = w_be16[2*NB-1:0];
    // Beat1 sits above beat0 so a right shift by the offset aligns the access.
    w_merge  = {i_beat1, i_beat0} >> {i_off, 3'b000};
    w_ext    = extend(64'(w_merge[DATA_W-1:0]), i_size, i_uns);
  end

  assign o_wdata0 = w_wide[DATA_W-1:0];
  assign o_wdata1 = w_wide[2*DATA_W-1:DATA_W];
  assign o_be0    = w_be2[NB-1:0];
  assign o_be1    = w_be2[2*NB-1:NB];
  assign o_rdata  = w_ext[DATA_W-1:0];

endmodule : mem_align_shifter
`default_nettype wire

// File: rtl/mem_align_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mem_align_bridge
// Purpose  : Unaligned load/store bridge in front of a busy-handshake memory
//            controller. Define MEM_ALIGN_SPLIT_EN to split word-crossing
//            accesses into two beats; otherwise they are rejected.
// Revision : 1.0 - initial release
// ============================================================================
module mem_align_bridge
  import mem_align_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_x,
  input  logic                 i_rd_en,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [DATA_W-1:0]    i_data,
  input  logic [2:0]           i_ctrl,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_busy,
  output logic                 o_err,
  output logic                 o_m_rd,
  output logic                 o_m_wr,
  output logic [ADDR_W-1:0]    o_m_addr,
  output logic [DATA_W-1:0]    o_m_wdata,
  output logic [DATA_W/8-1:0]  o_m_be,
  input  logic [DATA_W-1:0]    i_m_rdata,
  input  logic                 i_m_busy
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  state_t            r_state;
  state_t            w_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_ctrl;
  logic              r_is_rd;
  logic              r_rej;
  logic              r_stall;
  logic              r_err;
  logic [DATA_W-1:0] r_beat0;
  logic [DATA_W-1:0] r_rd_data;
`ifdef MEM_ALIGN_SPLIT_EN
  logic              r_cross;
  logic [DATA_W-1:0] r_beat1;
`endif

  logic              w_accept;
  logic [4:0]        w_span;
  logic              w_cross_in;
  logic              w_bad_size;
  logic              w_rej_in;
  logic              w_in_b1;
  logic              w_strobe;
  logic [ADDR_W-1:0] w_beat0_addr;
  logic [DATA_W-1:0] w_beat1;
  logic [DATA_W-1:0] w_wd0;
  logic [DATA_W-1:0] w_wd1;
  logic [NB-1:0]     w_be0;
  logic [NB-1:0]     w_be1;
  logic [DATA_W-1:0] w_rdata;

  assign w_accept   = (r_state == ST_IDLE) && (i_rd_en || i_wr_en) && !o_busy;
  assign w_span     = 5'(i_addr[OFF_W-1:0]) + (5'd1 << i_ctrl[1:0]);
  assign w_cross_in = w_span > 5'(NB);
  assign w_bad_size = i_ctrl[1:0] > 2'(OFF_W);

`ifdef MEM_ALIGN_SPLIT_EN
  assign w_rej_in = w_bad_size;
  assign w_in_b1  = (r_state == ST_REQ1) || (r_state == ST_WAIT1);
  assign w_strobe = (r_state == ST_REQ0) || (r_state == ST_REQ1);
  assign w_beat1  = r_cross ? r_beat1 : '0;
`else
  assign w_rej_in = w_bad_size || w_cross_in;
  assign w_in_b1  = 1'b0;
  assign w_strobe = (r_state == ST_REQ0);
  assign w_beat1  = '0;
`endif

  mem_align_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .i_off    (r_addr[OFF_W-1:0]),
    .i_size   (r_ctrl[1:0]),
    .i_uns    (r_ctrl[2]),
    .i_wdata  (r_wdata),
    .i_beat0  (r_beat0),
    .i_beat1  (w_beat1),
    .o_wdata0 (w_wd0),
    .o_wdata1 (w_wd1),
    .o_be0    (w_be0),
    .o_be1    (w_be1),
    .o_rdata  (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ctrl    <= '0;
      r_is_rd   <= 1'b0;
      r_rej     <= 1'b0;
      r_stall   <= 1'b0;
      r_err     <= 1'b0;
      r_beat0   <= '0;
      r_rd_data <= '0;
`ifdef MEM_ALIGN_SPLIT_EN
      r_cross   <= 1'b0;
      r_beat1   <= '0;
`endif
    end else begin
      r_state <= w_nxt;
      // Registered so a rejected access stays busy one extra cycle with the error.
      r_err   <= (r_state == ST_DONE) && r_rej;
      if (w_accept) begin
        r_addr  <= i_addr;
        r_wdata <= i_data;
        r_ctrl  <= i_ctrl;
        r_is_rd <= i_rd_en;
        r_rej   <= w_rej_in;
        r_stall <= 1'b1;
`ifdef MEM_ALIGN_SPLIT_EN
        r_cross <= w_cross_in;
`endif
      end else if (r_state == ST_DONE) begin
        r_stall <= 1'b0;
      end
      if ((r_state == ST_WAIT0) && !i_m_busy && r_is_rd) begin
        r_beat0 <= i_m_rdata;
      end
`ifdef MEM_ALIGN_SPLIT_EN
      if ((r_state == ST_WAIT1) && !i_m_busy && r_is_rd) begin
        r_beat1 <= i_m_rdata;
      end
`endif
      if ((r_state == ST_DONE) && r_is_rd && !r_rej) begin
        r_rd_data <= w_rdata;
      end
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_nxt = w_rej_in ? ST_DONE : ST_REQ0;
      ST_REQ0:  if (i_m_busy) w_nxt = ST_WAIT0;
      ST_WAIT0: begin
        if (!i_m_busy) begin
`ifdef MEM_ALIGN_SPLIT_EN
          w_nxt = r_cross ? ST_REQ1 : ST_DONE;
`else
          w_nxt = ST_DONE;
`endif
        end
      end
`ifdef MEM_ALIGN_SPLIT_EN
      ST_REQ1:  if (i_m_busy) w_nxt = ST_WAIT1;
      ST_WAIT1: if (!i_m_busy) w_nxt = ST_DONE;
`endif
      ST_DONE:  w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  assign w_beat0_addr = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign o_m_rd    = w_strobe && r_is_rd;
  assign o_m_wr    = w_strobe && !r_is_rd;
  assign o_m_addr  = w_in_b1 ? (w_beat0_addr + ADDR_W'(NB)) : w_beat0_addr;
  assign o_m_wdata = w_in_b1 ? w_wd1 : w_wd0;
  assign o_m_be    = o_m_wr ? (w_in_b1 ? w_be1 : w_be0) : '0;
  assign o_data    = r_rd_data;
  assign o_err     = r_err;
  assign o_busy    = r_stall || r_err || i_m_busy;

endmodule : mem_align_bridge
`default_nettype wire

// File: tb/tb_mem_align_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_align_bridge
// Purpose  : Self-checking bench for mem_align_bridge (DATA_W = 32, B = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_align_bridge;

`ifdef MEM_ALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  localparam int B = 3;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  ctrl;
    logic        err;
    logic        ld;
    logic [31:0] od;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  b0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  b1;
    logic [31:0] w1;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        i_rd_en, i_wr_en;
  logic [31:0] i_addr, i_data;
  logic [2:0]  i_ctrl;
  logic [31:0] o_data;
  logic        o_busy, o_err, o_m_rd, o_m_wr;
  logic [31:0] o_m_addr, o_m_wdata;
  logic [3:0]  o_m_be;
  logic [31:0] i_m_rdata = 32'd0;
  logic        i_m_busy  = 1'b0;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_od = 32'd0;
  logic [31:0] mem [logic [31:0]];
  beat_t       obs_q[$];
  vec_t        vecs[$];
  int          m_cnt = 0;

  always #5 clk = ~clk;

  mem_align_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_x     (rst_x),
    .i_rd_en   (i_rd_en),
    .i_wr_en   (i_wr_en),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .i_ctrl    (i_ctrl),
    .o_data    (o_data),
    .o_busy    (o_busy),
    .o_err     (o_err),
    .o_m_rd    (o_m_rd),
    .o_m_wr    (o_m_wr),
    .o_m_addr  (o_m_addr),
    .o_m_wdata (o_m_wdata),
    .o_m_be    (o_m_be),
    .i_m_rdata (i_m_rdata),
    .i_m_busy  (i_m_busy)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'd0;
  endfunction

  // Controller model: busy rises the cycle after a strobe and stays high B cycles.
  always @(posedge clk) begin
    if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) i_m_busy <= 1'b0;
    end else if (o_m_rd || o_m_wr) begin
      i_m_busy  <= 1'b1;
      m_cnt     <= B;
      i_m_rdata <= mem_rd(o_m_addr);
      obs_q.push_back('{wr: o_m_wr, addr: o_m_addr, wdata: o_m_wdata, be: o_m_be});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [2:0] ctrl,
                              input logic err, input logic ld, input logic [31:0] od,
                              input int nb, input logic [31:0] a0, input logic [3:0] b0,
                              input logic [31:0] w0, input logic [31:0] a1,
                              input logic [3:0] b1, input logic [31:0] w1);
    vec_t v;
    v = '{rd: rd, wr: wr, addr: addr, data: data, ctrl: ctrl, err: err, ld: ld, od: od,
          nb: nb, a0: a0, b0: b0, w0: w0, a1: a1, b1: b1, w1: w1};
    return v;
  endfunction

  function automatic vec_t mkerr(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [2:0] ctrl);
    return mk(rd, wr, addr, data, ctrl, 1'b1, 1'b0, 32'd0, 0, 32'd0, 4'd0, 32'd0,
              32'd0, 4'd0, 32'd0);
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc, busy_cyc, err_cnt, err_cyc, n;
    bit   done;
    beat_t ob;
    @(negedge clk);
    i_rd_en = v.rd; i_wr_en = v.wr; i_addr = v.addr; i_data = v.data; i_ctrl = v.ctrl;
    @(posedge clk);
    #1;
    i_rd_en = 1'b0; i_wr_en = 1'b0;
    cyc = 0; busy_cyc = 0; err_cnt = 0; err_cyc = -1; done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (o_err) begin err_cnt++; err_cyc = cyc; end
      if (o_busy) busy_cyc++;
      else done = 1'b1;
    end
    chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d_err", idx), err_cnt, v.err ? 32'd1 : 32'd0);
    if (v.err) begin
      chk($sformatf("v%0d_rej_busy_cycles", idx), busy_cyc, 32'd2);
      chk($sformatf("v%0d_rej_err_cycle", idx), err_cyc, 32'd2);
    end
    chk($sformatf("v%0d_beats", idx), obs_q.size(), v.nb);
    n = (obs_q.size() < v.nb) ? obs_q.size() : v.nb;
    for (int i = 0; i < n; i++) begin
      ob = obs_q.pop_front();
      chk($sformatf("v%0d_b%0d_wr", idx, i), 32'(ob.wr), 32'(!v.rd));
      chk($sformatf("v%0d_b%0d_addr", idx, i), ob.addr, (i == 0) ? v.a0 : v.a1);
      chk($sformatf("v%0d_b%0d_be", idx, i), 32'(ob.be), 32'((i == 0) ? v.b0 : v.b1));
      if (!v.rd) chk($sformatf("v%0d_b%0d_wdata", idx, i), ob.wdata, (i == 0) ? v.w0 : v.w1);
    end
    obs_q.delete();
    if (v.ld && !v.err) exp_od = v.od;
    chk($sformatf("v%0d_o_data", idx), o_data, exp_od);
  endtask

  initial begin
    int cyc;
    mem[32'h0000_0010] = 32'h1234_5678;
    mem[32'h0000_0100] = 32'h4433_2211;
    mem[32'h0000_0104] = 32'h8877_6655;
    mem[32'h0000_01FC] = 32'hAABB_CCDD;
    mem[32'h0000_0200] = 32'h1122_3380;

    vecs.push_back(SPLIT ?
      mk(0, 1, 32'h103, 32'h1122_3344, 3'b010, 0, 0, 0, 2,
         32'h100, 4'b1000, 32'h4400_0000, 32'h104, 4'b0111, 32'h0011_2233) :
      mkerr(0, 1, 32'h103, 32'h1122_3344, 3'b010));
    vecs.push_back(SPLIT ?
      mk(1, 0, 32'h1FF, 0, 3'b001, 0, 1, 32'hFFFF_80AA, 2, 32'h1FC, 0, 0, 32'h200, 0, 0) :
      mkerr(1, 0, 32'h1FF, 0, 3'b001));
    vecs.push_back(SPLIT ?
      mk(1, 0, 32'h1FF, 0, 3'b101, 0, 1, 32'h0000_80AA, 2, 32'h1FC, 0, 0, 32'h200, 0, 0) :
      mkerr(1, 0, 32'h1FF, 0, 3'b101));
    vecs.push_back(mk(1, 0, 32'h102, 0, 3'b000, 0, 1, 32'h0000_0033, 1, 32'h100, 0, 0, 0, 0, 0));
    vecs.push_back(SPLIT ?
      mk(0, 1, 32'hFFFF_FFFF, 32'h0000_BEEF, 3'b001, 0, 0, 0, 2,
         32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000, 32'h0, 4'b0001, 32'h0000_00BE) :
      mkerr(0, 1, 32'hFFFF_FFFF, 32'h0000_BEEF, 3'b001));
    vecs.push_back(mk(1, 1, 32'h10, 32'hCAFE_F00D, 3'b010, 0, 1, 32'h1234_5678, 1,
                      32'h10, 0, 0, 0, 0, 0));
    vecs.push_back(mkerr(1, 0, 32'h20, 0, 3'b011));
    vecs.push_back(SPLIT ?
      mk(1, 0, 32'h102, 0, 3'b010, 0, 1, 32'h6655_4433, 2, 32'h100, 0, 0, 32'h104, 0, 0) :
      mkerr(1, 0, 32'h102, 0, 3'b010));
    vecs.push_back(mk(1, 0, 32'h1FC, 0, 3'b000, 0, 1, 32'hFFFF_FFDD, 1, 32'h1FC, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h1FD, 0, 3'b100, 0, 1, 32'h0000_00CC, 1, 32'h1FC, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h21, 32'h1234_56A5, 3'b000, 0, 0, 0, 1,
                      32'h20, 4'b0010, 32'h0000_A500, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h40, 32'hDEAD_BEEF, 3'b010, 0, 0, 0, 1,
                      32'h40, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h102, 32'h1234_ABCD, 3'b001, 0, 0, 0, 1,
                      32'h100, 4'b1100, 32'hABCD_0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h1FE, 0, 3'b001, 0, 1, 32'hFFFF_AABB, 1, 32'h1FC, 0, 0, 0, 0, 0));
    vecs.push_back(mkerr(0, 1, 32'h0, 32'h1, 3'b111));

    rst_x = 1'b0; i_rd_en = 1'b0; i_wr_en = 1'b0;
    i_addr = 32'd0; i_data = 32'd0; i_ctrl = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_o_busy", 32'(o_busy), 32'd0);
    chk("rst_o_err", 32'(o_err), 32'd0);
    chk("rst_strobes", {30'd0, o_m_rd, o_m_wr}, 32'd0);
    chk("rst_o_m_addr", o_m_addr, 32'd0);
    chk("rst_o_m_wdata", o_m_wdata, 32'd0);
    chk("rst_o_m_be", 32'(o_m_be), 32'd0);
    chk("rst_o_data", o_data, 32'd0);
    rst_x = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset asserted while the bridge waits on an issued read beat.
    @(negedge clk);
    i_rd_en = 1'b1; i_addr = 32'h100; i_ctrl = 3'b010;
    @(posedge clk);
    #1;
    i_rd_en = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(i_m_busy && !o_m_rd) && cyc < 50);
    chk("wait0_reached", 32'(cyc < 50), 32'd1);
    #1 rst_x = 1'b0;
    #1;
    chk("midrst_strobes", {30'd0, o_m_rd, o_m_wr}, 32'd0);
    chk("midrst_o_busy", 32'(o_busy), 32'(i_m_busy));
    chk("midrst_o_busy_high", 32'(o_busy), 32'd1);
    chk("midrst_o_data", o_data, 32'd0);
    exp_od = 32'd0;
    cyc = 0;
    while (i_m_busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst_ctrl_idle", 32'(i_m_busy), 32'd0);
    chk("midrst_beat_issued", obs_q.size(), 32'd1);
    obs_q.delete();
    @(negedge clk);
    rst_x = 1'b1;
    run_vec(mk(1, 0, 32'h102, 0, 3'b000, 0, 1, 32'h0000_0033, 1, 32'h100, 0, 0, 0, 0, 0), 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_mem_align_bridge
`default_nettype wire
